// File: rtl/lcd_cmd_ctrl.sv
// HD44780 8-bit write sequencer fed by LSU stores to the LCD register.
// Each store becomes one timed setup/EN-pulse/hold/execute cycle with a 1-deep pending slot.
module lcd_cmd_ctrl #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_LONG  = 82000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_en_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] status_o,
  output logic        lcd_on_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic [7:0]  lcd_data_o
);

  localparam int unsigned MaxSp  = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int unsigned MaxShp = (MaxSp > T_HOLD) ? MaxSp : T_HOLD;
  localparam int unsigned MaxEl  = (T_EXEC > T_LONG) ? T_EXEC : T_LONG;
  localparam int unsigned TMax   = (MaxShp > MaxEl) ? MaxShp : MaxEl;
  localparam int unsigned CntW   = $clog2(TMax + 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StPulse = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
  localparam logic [2:0] StWait  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rs_q, rs_d, on_q, on_d;
  logic [7:0]      data_q, data_d;
  logic            pend_q, pend_d, pend_rs_q, pend_rs_d, pend_on_q, pend_on_d;
  logic [7:0]      pend_data_q, pend_data_d;
  logic            ovf_q, ovf_d;

  logic wr_txn, wr_ctrl, cnt_done, is_long, wait_done, busy;
  logic unused_wr_bits;

  assign wr_txn    = wr_en_i & ~wr_data_i[30];
  assign wr_ctrl   = wr_en_i & wr_data_i[30];
  assign cnt_done  = (cnt_q == '0);
  assign wait_done = (state_q == StWait) && cnt_done;
  // Clear display / return home need the long execute time.
  assign is_long   = ~rs_q && (data_q >= 8'h01) && (data_q <= 8'h03);
  assign unused_wr_bits = ^wr_data_i[29:9];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rs_d        = rs_q;
    data_d      = data_q;
    on_d        = on_q;
    pend_d      = pend_q;
    pend_rs_d   = pend_rs_q;
    pend_data_d = pend_data_q;
    pend_on_d   = pend_on_q;
    ovf_d       = ovf_q;

    if (wr_ctrl) begin
      ovf_d = 1'b0;
    end

    if (wr_txn && (state_q != StIdle) && !wait_done) begin
      if (pend_q) begin
        ovf_d = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_rs_d   = wr_data_i[8];
        pend_data_d = wr_data_i[7:0];
        pend_on_d   = wr_data_i[31];
      end
    end

    unique case (state_q)
      StIdle: begin
        if (wr_txn) begin
          state_d = StSetup;
          cnt_d   = CntW'(T_SETUP - 1);
          rs_d    = wr_data_i[8];
          data_d  = wr_data_i[7:0];
          on_d    = wr_data_i[31];
        end
      end
      StSetup: begin
        if (cnt_done) begin
          state_d = StPulse;
          cnt_d   = CntW'(T_PULSE - 1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StPulse: begin
        if (cnt_done) begin
          state_d = StHold;
          cnt_d   = CntW'(T_HOLD - 1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (cnt_done) begin
          state_d = StWait;
          cnt_d   = is_long ? CntW'(T_LONG - 1) : CntW'(T_EXEC - 1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWait: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (pend_q) begin
          // Pending entry goes straight to SETUP; a same-cycle write refills the slot.
          state_d = StSetup;
          cnt_d   = CntW'(T_SETUP - 1);
          rs_d    = pend_rs_q;
          data_d  = pend_data_q;
          on_d    = pend_on_q;
          pend_d  = wr_txn;
          if (wr_txn) begin
            pend_rs_d   = wr_data_i[8];
            pend_data_d = wr_data_i[7:0];
            pend_on_d   = wr_data_i[31];
          end
        end else if (wr_txn) begin
          state_d = StSetup;
          cnt_d   = CntW'(T_SETUP - 1);
          rs_d    = wr_data_i[8];
          data_d  = wr_data_i[7:0];
          on_d    = wr_data_i[31];
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      on_q        <= 1'b0;
      pend_q      <= 1'b0;
      pend_rs_q   <= 1'b0;
      pend_data_q <= 8'h00;
      pend_on_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      on_q        <= on_d;
      pend_q      <= pend_d;
      pend_rs_q   <= pend_rs_d;
      pend_data_q <= pend_data_d;
      pend_on_q   <= pend_on_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign status_o   = {on_q, 28'd0, ovf_q, pend_q, busy};
  assign lcd_on_o   = on_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_rw_o   = 1'b0;
  assign lcd_en_o   = (state_q == StPulse);
  assign lcd_data_o = data_q;

endmodule
